key_input_conditioner: RTL



---
 rtl/key_input_conditioner.sv | 91 +++++++++
 1 files changed

// File: rtl/key_input_conditioner.sv
// Push-button conditioner: two-flop synchroniser, per-key debounce counter and
// sticky press-event flags that the CPU clears by reading the KEY register.
module key_input_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EVENT_MODE      = 1,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw_n,
  input  logic                clr_evt,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_evt,
  output logic                key_evt_any,
  output logic [NUM_KEYS-1:0] key_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] s;
  logic [NUM_KEYS-1:0] accept;
  logic [NUM_KEYS-1:0] rise;
  logic [CNT_W-1:0]    cnt [NUM_KEYS];

  // Active-high synchronised level and per-key "level change accepted" strobes
  always_comb begin
    s      = ~sync2;
    accept = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if ((s[i] != key_level[i]) && (cnt[i] == CNT_MAX)) begin
        accept[i] = 1'b1;
      end else begin
        accept[i] = 1'b0;
      end
    end
    rise = accept & s;
  end

  // Two-flop synchroniser; resets to the released (high) pin state
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_raw_n;
      sync2 <= sync1;
    end
  end

  // Debounce counters: any agreement with the current level restarts the count
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (rst) begin
        cnt[i] <= '0;
      end else if (s[i] == key_level[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == CNT_MAX) begin
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Debounced level flips only when a change has been stable long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      key_level <= '0;
    end else begin
      key_level <= key_level ^ accept;
    end
  end

  // Sticky press flags; a press landing in the clearing cycle survives the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      key_evt <= '0;
    end else if (clr_evt) begin
      key_evt <= rise;
    end else begin
      key_evt <= key_evt | rise;
    end
  end

  assign key_evt_any = |key_evt;
  assign key_out     = (EVENT_MODE != 0) ? key_evt : key_level;

endmodule
